decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/riscv_pkg.sv | 35 +++
 rtl/reg_file.sv | 54 +++++
 rtl/decode_stage.sv | 110 +++++++++++
 tb/tb_decode_stage.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I constants, immediate-type enum and opcode helpers
package riscv_pkg;

    localparam logic [31:0] NOP = 32'h0000_0013;  // addi x0, x0, 0

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_type_e;

    function automatic logic is_rv32i_opcode(input logic [6:0] opcode);
        case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
            OP_STORE, OP_IMM, OP_REG, OP_FENCE, OP_SYSTEM: return 1'b1;
            default:                                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 32x32 register file, two combinational read ports, one write port
// Ports: clk, reset (async, active-high); ra1/ra2 read addresses, rd1/rd2 read data;
//        we/wa/wd write enable, address and data. x0 always reads 0; a write to the
//        address being read is forwarded to that read port in the same cycle.
module reg_file #(
    parameter bit ClearRegsOnReset = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);

    logic [31:0] regs [32];
    logic        wr_en;

    assign wr_en = we && (wa != 5'd0);

    generate
        if (ClearRegsOnReset) begin : g_clear
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < 32; i++) begin
                        regs[i] <= '0;
                    end
                end else if (wr_en) begin
                    regs[wa] <= wd;
                end
            end
        end else begin : g_keep
            // Contents survive reset, but a write coinciding with reset is dropped.
            always_ff @(posedge clk) begin
                if (wr_en && !reset) begin
                    regs[wa] <= wd;
                end
            end
        end
    endgenerate

    always_comb begin
        rd1 = regs[ra1];
        rd2 = regs[ra2];
        if (wr_en && (wa == ra1)) rd1 = wd;
        if (wr_en && (wa == ra2)) rd2 = wd;
        if (ra1 == 5'd0)          rd1 = '0;
        if (ra2 == 5'd0)          rd2 = '0;
    end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I decode stage: IF/ID register, register file, immediate gen
// Ports: clk, reset (async, active-high); instr_f/pc_f/pc4_f from fetch; stall/flush/halted
//        pipeline control; reg_write_w/rd_w/result_w writeback; instr_d/pc_d/pc4_d,
//        rs1_d/rs2_d/rd_d, rd1_d/rd2_d, imm_d to execute; pc_imm_d/jump_d back to fetch;
//        illegal_instr_d exception flag.
module decode_stage
    import riscv_pkg::*;
#(
    parameter bit ClearRegsOnReset = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_f,
    input  logic [31:0] pc_f,
    input  logic [31:0] pc4_f,
    input  logic        stall,
    input  logic        flush,
    input  logic        halted,
    input  logic        reg_write_w,
    input  logic [4:0]  rd_w,
    input  logic [31:0] result_w,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc4_d,
    output logic [4:0]  rs1_d,
    output logic [4:0]  rs2_d,
    output logic [4:0]  rd_d,
    output logic [31:0] rd1_d,
    output logic [31:0] rd2_d,
    output logic [31:0] imm_d,
    output logic [31:0] pc_imm_d,
    output logic        jump_d,
    output logic        illegal_instr_d
);

    logic [6:0] opcode;
    imm_type_e  imm_type;

    // halted freezes everything; flush beats stall so a squashed slot never lingers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_d <= NOP;
            pc_d    <= '0;
            pc4_d   <= '0;
        end else if (!halted) begin
            if (flush) begin
                instr_d <= NOP;
                pc_d    <= '0;
                pc4_d   <= '0;
            end else if (!stall) begin
                instr_d <= instr_f;
                pc_d    <= pc_f;
                pc4_d   <= pc4_f;
            end
        end
    end

    assign opcode = instr_d[6:0];
    assign rs1_d  = instr_d[19:15];
    assign rs2_d  = instr_d[24:20];
    assign rd_d   = instr_d[11:7];

    reg_file #(
        .ClearRegsOnReset(ClearRegsOnReset)
    ) u_reg_file (
        .clk  (clk),
        .reset(reset),
        .ra1  (rs1_d),
        .ra2  (rs2_d),
        .we   (reg_write_w),
        .wa   (rd_w),
        .wd   (result_w),
        .rd1  (rd1_d),
        .rd2  (rd2_d)
    );

    always_comb begin
        imm_type = IMM_NONE;
        case (opcode)
            OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: imm_type = IMM_I;
            OP_STORE:                            imm_type = IMM_S;
            OP_BRANCH:                           imm_type = IMM_B;
            OP_LUI, OP_AUIPC:                    imm_type = IMM_U;
            OP_JAL:                              imm_type = IMM_J;
            default:                             imm_type = IMM_NONE;
        endcase
    end

    always_comb begin
        imm_d = '0;
        case (imm_type)
            IMM_I:   imm_d = {{20{instr_d[31]}}, instr_d[31:20]};
            IMM_S:   imm_d = {{20{instr_d[31]}}, instr_d[31:25], instr_d[11:7]};
            IMM_B:   imm_d = {{19{instr_d[31]}}, instr_d[31], instr_d[7],
                              instr_d[30:25], instr_d[11:8], 1'b0};
            IMM_U:   imm_d = {instr_d[31:12], 12'b0};
            IMM_J:   imm_d = {{11{instr_d[31]}}, instr_d[31], instr_d[19:12],
                              instr_d[20], instr_d[30:21], 1'b0};
            default: imm_d = '0;
        endcase
    end

    assign pc_imm_d = pc_d + imm_d;

    // Gated live by flush/halted so fetch never redirects on a slot being killed or frozen.
    assign jump_d = (opcode == OP_JAL) && !flush && !halted;

    assign illegal_instr_d = !is_rv32i_opcode(opcode) || (instr_d[1:0] != 2'b11);

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage
module tb_decode_stage;

    localparam logic [31:0] NOP_I = 32'h0000_0013;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] imm;
        logic [31:0] pc_imm;
        logic        jump;
        logic        illegal;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks   = 0;
    int   failures = 0;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_f, pc_f, pc4_f;
    logic        stall, flush, halted;
    logic        reg_write_w;
    logic [4:0]  rd_w;
    logic [31:0] result_w;

    logic [31:0] instr_d, pc_d, pc4_d, rd1_d, rd2_d, imm_d, pc_imm_d;
    logic [4:0]  rs1_d, rs2_d, rd_d;
    logic        jump_d, illegal_instr_d;

    logic [31:0] k_instr_d, k_pc_d, k_pc4_d, k_rd1_d, k_rd2_d, k_imm_d, k_pc_imm_d;
    logic [4:0]  k_rs1_d, k_rs2_d, k_rd_d;
    logic        k_jump_d, k_illegal_instr_d;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .reset(reset), .instr_f(instr_f), .pc_f(pc_f), .pc4_f(pc4_f),
        .stall(stall), .flush(flush), .halted(halted),
        .reg_write_w(reg_write_w), .rd_w(rd_w), .result_w(result_w),
        .instr_d(instr_d), .pc_d(pc_d), .pc4_d(pc4_d),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
        .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_d(imm_d),
        .pc_imm_d(pc_imm_d), .jump_d(jump_d), .illegal_instr_d(illegal_instr_d)
    );

    decode_stage #(.ClearRegsOnReset(1'b0)) dut_keep (
        .clk(clk), .reset(reset), .instr_f(instr_f), .pc_f(pc_f), .pc4_f(pc4_f),
        .stall(stall), .flush(flush), .halted(halted),
        .reg_write_w(reg_write_w), .rd_w(rd_w), .result_w(result_w),
        .instr_d(k_instr_d), .pc_d(k_pc_d), .pc4_d(k_pc4_d),
        .rs1_d(k_rs1_d), .rs2_d(k_rs2_d), .rd_d(k_rd_d),
        .rd1_d(k_rd1_d), .rd2_d(k_rd2_d), .imm_d(k_imm_d),
        .pc_imm_d(k_pc_imm_d), .jump_d(k_jump_d), .illegal_instr_d(k_illegal_instr_d)
    );

    task automatic capture(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] pc4);
        @(negedge clk);
        instr_f = instr; pc_f = pc; pc4_f = pc4;
        stall = 1'b0; flush = 1'b0; halted = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        instr_f = 32'h0080_006F; pc_f = 32'h100; pc4_f = 32'h104;
        stall = 1'b0; flush = 1'b0; halted = 1'b0;
        reg_write_w = 1'b0; rd_w = 5'd0; result_w = '0;
        sb.push_back('{NOP_I, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0});
        repeat (2) @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        checks += 7;
        if (instr_d !== e.instr)           begin failures++; $display("FAIL reset_instr got=%h exp=%h", instr_d, e.instr); end
        if (pc_d !== e.pc)                 begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc_d, e.pc); end
        if (pc4_d !== e.pc4)               begin failures++; $display("FAIL reset_pc4 got=%h exp=%h", pc4_d, e.pc4); end
        if (imm_d !== e.imm)               begin failures++; $display("FAIL reset_imm got=%h exp=%h", imm_d, e.imm); end
        if (pc_imm_d !== e.pc_imm)         begin failures++; $display("FAIL reset_pc_imm got=%h exp=%h", pc_imm_d, e.pc_imm); end
        if (jump_d !== e.jump)             begin failures++; $display("FAIL reset_jump got=%b exp=%b", jump_d, e.jump); end
        if (illegal_instr_d !== e.illegal) begin failures++; $display("FAIL reset_illegal got=%b exp=%b", illegal_instr_d, e.illegal); end
        // first posedge with reset low captures
        reset = 1'b0;
        instr_f = 32'h00A0_0093; pc_f = 32'h40; pc4_f = 32'h44;
        sb.push_back('{32'h00A0_0093, 32'h40, 32'h44, 32'hA, 32'h4A, 1'b0, 1'b0});
        @(posedge clk); #1;
        e = sb.pop_front();
        checks += 3;
        if (instr_d !== e.instr)   begin failures++; $display("FAIL first_capture_instr got=%h exp=%h", instr_d, e.instr); end
        if (imm_d !== e.imm)       begin failures++; $display("FAIL first_capture_imm got=%h exp=%h", imm_d, e.imm); end
        if (pc_imm_d !== e.pc_imm) begin failures++; $display("FAIL first_capture_pc_imm got=%h exp=%h", pc_imm_d, e.pc_imm); end
    endtask

    task automatic test_jal();
        sb.push_back('{32'h0080_006F, 32'h100, 32'h104, 32'h8, 32'h108, 1'b1, 1'b0});
        capture(32'h0080_006F, 32'h100, 32'h104);
        e = sb.pop_front();
        checks += 5;
        if (instr_d !== e.instr)   begin failures++; $display("FAIL jal_instr got=%h exp=%h", instr_d, e.instr); end
        if (pc4_d !== e.pc4)       begin failures++; $display("FAIL jal_pc4 got=%h exp=%h", pc4_d, e.pc4); end
        if (jump_d !== e.jump)     begin failures++; $display("FAIL jal_jump got=%b exp=%b", jump_d, e.jump); end
        if (imm_d !== e.imm)       begin failures++; $display("FAIL jal_imm got=%h exp=%h", imm_d, e.imm); end
        if (pc_imm_d !== e.pc_imm) begin failures++; $display("FAIL jal_pc_imm got=%h exp=%h", pc_imm_d, e.pc_imm); end
        // flush masks jump_d combinationally, then loads NOP at the edge
        @(negedge clk);
        flush = 1'b1;
        #1;
        checks += 1;
        if (jump_d !== 1'b0) begin failures++; $display("FAIL jal_flush_mask got=%b exp=0", jump_d); end
        sb.push_back('{NOP_I, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0});
        @(posedge clk); #1;
        flush = 1'b0;
        e = sb.pop_front();
        checks += 2;
        if (instr_d !== e.instr) begin failures++; $display("FAIL jal_flush_instr got=%h exp=%h", instr_d, e.instr); end
        if (pc_d !== e.pc)       begin failures++; $display("FAIL jal_flush_pc got=%h exp=%h", pc_d, e.pc); end
    endtask

    task automatic test_bypass();
        capture(32'h0002_8093, 32'h10, 32'h14);  // addi x1, x5, 0
        @(negedge clk);
        reg_write_w = 1'b1; rd_w = 5'd5; result_w = 32'hDEAD_BEEF;
        #1;
        checks += 2;
        if (rs1_d !== 5'd5)          begin failures++; $display("FAIL bypass_rs1 got=%0d exp=5", rs1_d); end
        if (rd1_d !== 32'hDEAD_BEEF) begin failures++; $display("FAIL bypass_rd1 got=%h exp=deadbeef", rd1_d); end
        @(posedge clk); #1;
        reg_write_w = 1'b0;
        #1;
        checks += 1;
        if (rd1_d !== 32'hDEAD_BEEF) begin failures++; $display("FAIL stored_rd1 got=%h exp=deadbeef", rd1_d); end
        capture(32'h0050_00B3, 32'h14, 32'h18);  // add x1, x0, x5
        checks += 3;
        if (rs2_d !== 5'd5)          begin failures++; $display("FAIL rs2_field got=%0d exp=5", rs2_d); end
        if (rd2_d !== 32'hDEAD_BEEF) begin failures++; $display("FAIL stored_rd2 got=%h exp=deadbeef", rd2_d); end
        if (rd_d !== 5'd1)           begin failures++; $display("FAIL rd_field got=%0d exp=1", rd_d); end
        // x0 write is ignored both via bypass and in storage
        @(negedge clk);
        reg_write_w = 1'b1; rd_w = 5'd0; result_w = 32'h1234;
        #1;
        checks += 1;
        if (rd1_d !== 32'h0) begin failures++; $display("FAIL x0_bypass got=%h exp=0", rd1_d); end
        @(posedge clk); #1;
        reg_write_w = 1'b0;
        #1;
        checks += 1;
        if (rd1_d !== 32'h0) begin failures++; $display("FAIL x0_stored got=%h exp=0", rd1_d); end
    endtask

    task automatic test_stall_flush();
        @(negedge clk);
        instr_f = 32'h00A0_0093; pc_f = 32'h300; pc4_f = 32'h304;
        stall = 1'b1; flush = 1'b1;
        sb.push_back('{NOP_I, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0});
        @(posedge clk); #1;
        stall = 1'b0; flush = 1'b0;
        e = sb.pop_front();
        checks += 3;
        if (instr_d !== e.instr) begin failures++; $display("FAIL stflush_instr got=%h exp=%h", instr_d, e.instr); end
        if (pc_d !== e.pc)       begin failures++; $display("FAIL stflush_pc got=%h exp=%h", pc_d, e.pc); end
        if (jump_d !== e.jump)   begin failures++; $display("FAIL stflush_jump got=%b exp=%b", jump_d, e.jump); end
    endtask

    task automatic test_hold();
        capture(32'h00C0_006F, 32'h500, 32'h504);  // jal x0, 12
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            stall = 1'b1;
            instr_f = 32'h0000_0093 + (i << 20); pc_f = 32'h600 + i * 4;
            sb.push_back('{32'h00C0_006F, 32'h500, 32'h504, 32'hC, 32'h50C, 1'b1, 1'b0});
            @(posedge clk); #1;
            e = sb.pop_front();
            checks += 2;
            if (instr_d !== e.instr) begin failures++; $display("FAIL stall_hold_instr[%0d] got=%h exp=%h", i, instr_d, e.instr); end
            if (pc_d !== e.pc)       begin failures++; $display("FAIL stall_hold_pc[%0d] got=%h exp=%h", i, pc_d, e.pc); end
        end
        // halted beats flush; writeback still lands while halted
        @(negedge clk);
        stall = 1'b0; flush = 1'b1; halted = 1'b1;
        reg_write_w = 1'b1; rd_w = 5'd9; result_w = 32'h0000_0999;
        sb.push_back('{32'h00C0_006F, 32'h500, 32'h504, 32'hC, 32'h50C, 1'b0, 1'b0});
        @(posedge clk); #1;
        e = sb.pop_front();
        checks += 3;
        if (instr_d !== e.instr) begin failures++; $display("FAIL halt_instr got=%h exp=%h", instr_d, e.instr); end
        if (pc_imm_d !== e.pc_imm) begin failures++; $display("FAIL halt_pc_imm got=%h exp=%h", pc_imm_d, e.pc_imm); end
        if (jump_d !== e.jump)   begin failures++; $display("FAIL halt_jump got=%b exp=%b", jump_d, e.jump); end
        flush = 1'b0; halted = 1'b0; reg_write_w = 1'b0;
        capture(32'h0004_8093, 32'h20, 32'h24);  // addi x1, x9, 0
        checks += 1;
        if (rd1_d !== 32'h0000_0999) begin failures++; $display("FAIL halt_write_rd1 got=%h exp=00000999", rd1_d); end
    endtask

    task automatic test_imm();
        logic [31:0] tbl_instr [10] = '{32'hFE00_0EE3, 32'hFE00_0E63, 32'hFFC1_2083, 32'hFE51_2C23,
                                        32'h1234_50B7, 32'h8000_0097, 32'h0200_006F, 32'hFF80_80E7,
                                        32'h0000_007F, 32'h0000_0010};
        logic [31:0] tbl_pc    [10] = '{32'h200, 32'h200, 32'h0, 32'h8, 32'h0, 32'h10,
                                        32'hFFFF_FFF0, 32'h40, 32'h80, 32'h90};
        logic [31:0] tbl_imm   [10] = '{32'hFFFF_FFFC, 32'hFFFF_F7FC, 32'hFFFF_FFFC, 32'hFFFF_FFF8,
                                        32'h1234_5000, 32'h8000_0000, 32'h0000_0020, 32'hFFFF_FFF8,
                                        32'h0, 32'h0};
        logic        tbl_ill   [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic        tbl_jmp   [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 10; i++) begin
            sb.push_back('{tbl_instr[i], tbl_pc[i], tbl_pc[i] + 32'd4, tbl_imm[i],
                           tbl_pc[i] + tbl_imm[i], tbl_jmp[i], tbl_ill[i]});
            capture(tbl_instr[i], tbl_pc[i], tbl_pc[i] + 32'd4);
            e = sb.pop_front();
            checks += 4;
            if (imm_d !== e.imm)               begin failures++; $display("FAIL imm[%0d] got=%h exp=%h", i, imm_d, e.imm); end
            if (pc_imm_d !== e.pc_imm)         begin failures++; $display("FAIL pc_imm[%0d] got=%h exp=%h", i, pc_imm_d, e.pc_imm); end
            if (jump_d !== e.jump)             begin failures++; $display("FAIL jump[%0d] got=%b exp=%b", i, jump_d, e.jump); end
            if (illegal_instr_d !== e.illegal) begin failures++; $display("FAIL illegal[%0d] got=%b exp=%b", i, illegal_instr_d, e.illegal); end
        end
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        reg_write_w = 1'b1; rd_w = 5'd7; result_w = 32'd5;
        @(posedge clk); #1;
        reg_write_w = 1'b0;
        capture(32'h0003_8093, 32'h30, 32'h34);  // addi x1, x7, 0
        checks += 2;
        if (rd1_d !== 32'd5)   begin failures++; $display("FAIL pre_reset_rd1 got=%h exp=5", rd1_d); end
        if (k_rd1_d !== 32'd5) begin failures++; $display("FAIL pre_reset_keep_rd1 got=%h exp=5", k_rd1_d); end
        // async assertion between edges, held across an edge carrying a write to x7
        #2;
        reset = 1'b1;
        reg_write_w = 1'b1; rd_w = 5'd7; result_w = 32'd9;
        #1;
        checks += 2;
        if (instr_d !== NOP_I) begin failures++; $display("FAIL async_reset_instr got=%h exp=%h", instr_d, NOP_I); end
        if (pc_d !== 32'h0)    begin failures++; $display("FAIL async_reset_pc got=%h exp=0", pc_d); end
        @(posedge clk); #1;
        @(negedge clk);
        reset = 1'b0; reg_write_w = 1'b0;
        capture(32'h0003_8093, 32'h30, 32'h34);
        checks += 2;
        if (rd1_d !== 32'd0)   begin failures++; $display("FAIL post_reset_clear_rd1 got=%h exp=0", rd1_d); end
        if (k_rd1_d !== 32'd5) begin failures++; $display("FAIL post_reset_keep_rd1 got=%h exp=5", k_rd1_d); end
    endtask

    initial begin
        test_reset();
        test_jal();
        test_bypass();
        test_stall_flush();
        test_hold();
        test_imm();
        test_reset_mid_run();
        if (sb.size() != 0) begin
            checks++; failures++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
